// File: rtl/fabric_pe_load_queued.sv
// fabric_pe_load_queued
//   Multi-outstanding memory load adapter. An address token (in0) and a
//   control token (in1) are joined. For HW_TYPE 1 their tags must also match.
//   The joined pair issues the address to memory (out0). Each issue records a
//   response tag in an in-order tag queue, so up to QUEUE_DEPTH loads can be
//   in flight. Memory data (in2) comes back in issue order. It is paired with
//   the queue head tag and returned to compute (out1) through a 1-entry
//   output register.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in0_valid/ready/data [PW]     address from compute, {tag, value}
//   in1_valid/ready/data [PW]     control token, tag in [TAG_WIDTH-1:0]
//   in2_valid/ready/data [DW]     load data from memory
//   out0_valid/ready/data [DW]    address to memory
//   out1_valid/ready/data [PW]    load result to compute, {tag, value}
//   cfg_data [TW]                 response tag for HW_TYPE 0 (tagged)
//   outstanding [CW]              current tag-queue occupancy
//   err_orphan                    sticky: memory data arrived with no load pending
module fabric_pe_load_queued #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 0,
  parameter int HW_TYPE     = 0,
  parameter int QUEUE_DEPTH = 4,
  localparam int PW = ((DATA_WIDTH + TAG_WIDTH) > 1) ? (DATA_WIDTH + TAG_WIDTH) : 1,
  localparam int CW = $clog2(QUEUE_DEPTH + 1),
  localparam int TW = (TAG_WIDTH > 1) ? TAG_WIDTH : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_valid,
  output logic                  in0_ready,
  input  logic [PW-1:0]         in0_data,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [PW-1:0]         in1_data,
  input  logic                  in2_valid,
  output logic                  in2_ready,
  input  logic [DATA_WIDTH-1:0] in2_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [PW-1:0]         out1_data,
  input  logic [TW-1:0]         cfg_data,
  output logic [CW-1:0]         outstanding,
  output logic                  err_orphan
);

  // Elaboration-time legality checks on the parameter set.
  if (DATA_WIDTH < 1) begin : g_bad_dw
    $fatal(1, "fabric_pe_load_queued: DATA_WIDTH must be >= 1");
  end
  if ((HW_TYPE != 0) && (HW_TYPE != 1)) begin : g_bad_hw
    $fatal(1, "fabric_pe_load_queued: HW_TYPE must be 0 or 1");
  end
  if ((HW_TYPE == 1) && (TAG_WIDTH == 0)) begin : g_bad_tag
    $fatal(1, "fabric_pe_load_queued: HW_TYPE 1 needs TAG_WIDTH > 0");
  end
  if (QUEUE_DEPTH < 1) begin : g_bad_depth
    $fatal(1, "fabric_pe_load_queued: QUEUE_DEPTH must be >= 1");
  end

  localparam int               PTRW     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(QUEUE_DEPTH);
  localparam logic [PTRW-1:0]  LAST_PTR = PTRW'(QUEUE_DEPTH - 1);

  logic [TW-1:0]   tag_mem_r [QUEUE_DEPTH];
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [PW-1:0]   out1_data_r;
  logic            out1_valid_r;
  logic            err_orphan_r;

  logic [TW-1:0]   addr_tag_s;
  logic [TW-1:0]   ctrl_tag_s;
  logic [TW-1:0]   push_tag_s;
  logic [TW-1:0]   head_tag_s;
  logic [PW-1:0]   ret_word_s;
  logic            tag_ok_s;
  logic            sync_s;
  logic            issue_fire_s;
  logic            ret_fire_s;
  logic            in2_ready_s;
  logic            unused_s;

  // Tag fields only exist when the build is tagged. Untagged builds see a constant zero tag.
  if (TAG_WIDTH > 0) begin : g_tagged
    assign addr_tag_s = in0_data[PW-1 -: TW];
    assign ctrl_tag_s = in1_data[TW-1:0];
    assign ret_word_s = {head_tag_s, in2_data};
  end else begin : g_untagged
    assign addr_tag_s = {TW{1'b0}};
    assign ctrl_tag_s = {TW{1'b0}};
    assign ret_word_s = in2_data;
  end

  // Bits that are legitimately unused in some parameterisations.
  assign unused_s = ^{in0_data, in1_data, cfg_data, head_tag_s};

  assign head_tag_s = tag_mem_r[rd_ptr_r];

  // Issue gating and selection of the tag to record.
  always_comb begin
    tag_ok_s   = 1'b1;
    push_tag_s = {TW{1'b0}};
    if (HW_TYPE == 1) begin
      tag_ok_s   = (addr_tag_s == ctrl_tag_s);
      push_tag_s = addr_tag_s;
    end else if (TAG_WIDTH > 0) begin
      push_tag_s = cfg_data;
    end else begin
      push_tag_s = {TW{1'b0}};
    end
  end

  // A full queue blocks issue. A pop in the same cycle does not bypass, so the slot frees next cycle.
  assign sync_s       = in0_valid & in1_valid & tag_ok_s & (count_r < DEPTH_C);
  assign issue_fire_s = sync_s & out0_ready;
  assign in2_ready_s  = (count_r != {CW{1'b0}}) & (~out1_valid_r | out1_ready);
  assign ret_fire_s   = in2_valid & in2_ready_s;

  assign out0_valid  = sync_s;
  assign out0_data   = in0_data[DATA_WIDTH-1:0];
  assign in0_ready   = issue_fire_s;
  assign in1_ready   = issue_fire_s;
  assign in2_ready   = in2_ready_s;
  assign out1_valid  = out1_valid_r;
  assign out1_data   = out1_data_r;
  assign outstanding = count_r;
  assign err_orphan  = err_orphan_r;

  // Tag queue storage: write the recorded tag at the write pointer on every issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        tag_mem_r[i] <= {TW{1'b0}};
      end
    end else if (issue_fire_s) begin
      tag_mem_r[wr_ptr_r] <= push_tag_s;
    end
  end

  // Queue pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (issue_fire_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PTRW{1'b0}} : wr_ptr_r + PTRW'(1);
      end
      if (ret_fire_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTRW{1'b0}} : rd_ptr_r + PTRW'(1);
      end
      case ({issue_fire_s, ret_fire_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Return register: capture memory data with its head tag; an out1 handshake without a refill empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_valid_r <= 1'b0;
      out1_data_r  <= {PW{1'b0}};
    end else if (ret_fire_s) begin
      out1_valid_r <= 1'b1;
      out1_data_r  <= ret_word_s;
    end else if (out1_ready) begin
      out1_valid_r <= 1'b0;
    end
  end

  // Sticky error: memory data arrived while no load was pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_orphan_r <= 1'b0;
    end else if (in2_valid && (count_r == {CW{1'b0}})) begin
      err_orphan_r <= 1'b1;
    end
  end

endmodule
